img_rsz_blk_acc: RTL and testbench

Block-gather stage of the image resizer. Takes raster-order source pixels and sums them per primary colour over BlkSzHor×BlkSzVer blocks, using one running accumulator per resized-image column. When a block's last pixel is captured, it presents the block sum and one-hot X/Y position masks to the compute engine over a valid/ready handshake. It is the transmitting end of the CompBlk interface and the source of the first-pixel/capture strobes the compute engine uses to size blocks.

---
 rtl/img_rsz_blk_acc_pkg.sv | 39 +++
 rtl/img_rsz_blk_acc_if.sv | 27 ++
 rtl/img_rsz_blk_acc_acc_row.sv | 32 +++
 rtl/img_rsz_blk_acc.sv | 157 +++++++++++++++
 tb/tb_img_rsz_blk_acc.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_rsz_blk_acc_pkg.sv
// Shared types and sizing for the image resizer block-gather stage.
package img_rsz_blk_acc_pkg;

  // Resized image geometry (one accumulator per resized column).
  localparam int RSZ_IMG_WIDTH_SIZE  = 2;
  localparam int RSZ_IMG_HEIGHT_SIZE = 2;

  // Pixel format.
  localparam int PXL_PRIM_COLOR_NUM = 3;
  localparam int PXL_PRIM_COLOR_W   = 8;

  // Largest block the resizer supports, and the widths that carry block sizes.
  localparam int BLK_WIDTH_MAX_SZ    = 4;
  localparam int BLK_HEIGHT_MAX_SZ   = 4;
  localparam int BLK_WIDTH_MAX_SZ_W  = $clog2(BLK_WIDTH_MAX_SZ + 1);
  localparam int BLK_HEIGHT_MAX_SZ_W = $clog2(BLK_HEIGHT_MAX_SZ + 1);

  // n * (2^w - 1) < 2^(w + clog2(n)), so the largest block sum never wraps.
  localparam int BLK_SUM_MAX_W = PXL_PRIM_COLOR_W + $clog2(BLK_WIDTH_MAX_SZ * BLK_HEIGHT_MAX_SZ);

  // Counter width that stays legal for a single-entry range.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int BLK_X_W = cnt_w(RSZ_IMG_WIDTH_SIZE);
  localparam int BLK_Y_W = cnt_w(RSZ_IMG_HEIGHT_SIZE);

  typedef logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0] FcPxl_t;
  typedef logic [PXL_PRIM_COLOR_NUM-1:0][BLK_SUM_MAX_W-1:0]    FcBlkVal_t;

  // Frame sequencing states, shared with the compute engine.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } BlkAccSt_t;

endpackage

// File: rtl/img_rsz_blk_acc_if.sv
// CompBlk handshake between the block-gather stage (master) and the compute engine (slave).
interface img_rsz_blk_acc_if;
  import img_rsz_blk_acc_pkg::*;

  FcBlkVal_t                      CompBlkData;
  logic [RSZ_IMG_WIDTH_SIZE-1:0]  CompBlkXMsk;
  logic [RSZ_IMG_HEIGHT_SIZE-1:0] CompBlkYMsk;
  logic                           CompBlkVld;
  logic                           CompBlkRdy;

  modport master (
    output CompBlkData,
    output CompBlkXMsk,
    output CompBlkYMsk,
    output CompBlkVld,
    input  CompBlkRdy
  );

  modport slave (
    input  CompBlkData,
    input  CompBlkXMsk,
    input  CompBlkYMsk,
    input  CompBlkVld,
    output CompBlkRdy
  );

endinterface

// File: rtl/img_rsz_blk_acc_acc_row.sv
// One running per-colour accumulator per resized column. The addressed entry is
// read, optionally cleared (first pixel of a block), summed with the pixel and
// written back in the same cycle; the summed value is also exported so the
// parent can capture a finished block without waiting for the write-back.
module img_rsz_acc_row
  import img_rsz_blk_acc_pkg::*;
(
  input  logic               clk,
  input  logic [BLK_X_W-1:0] idx,
  input  logic               wr_en,
  input  logic               load,
  input  FcPxl_t             pxl,
  output FcBlkVal_t          sum
);

  for (genvar gi = 0; gi < PXL_PRIM_COLOR_NUM; gi++) begin : g_color
    // Contents are never reset: every block starts with a load.
    logic [BLK_SUM_MAX_W-1:0] acc_mem [RSZ_IMG_WIDTH_SIZE];
    logic [BLK_SUM_MAX_W-1:0] base;

    assign base    = load ? '0 : acc_mem[idx];
    assign sum[gi] = base + BLK_SUM_MAX_W'(pxl[gi]);

    // Write back the updated running sum for the addressed column.
    always_ff @(posedge clk) begin
      if (wr_en) begin
        acc_mem[idx] <= sum[gi];
      end
    end
  end

endmodule

// File: rtl/img_rsz_blk_acc.sv
// Block-gather stage: sums raster-order pixels over BlkSzHor x BlkSzVer blocks
// and hands each finished block to the compute engine over CompBlk.
module img_rsz_blk_acc
  import img_rsz_blk_acc_pkg::*;
(
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic [BLK_WIDTH_MAX_SZ_W-1:0]  BlkSzHor,
  input  logic [BLK_HEIGHT_MAX_SZ_W-1:0] BlkSzVer,
  input  FcPxl_t                         PxlData,
  input  logic                           PxlVld,
  output logic                           PxlRdy,
  output logic                           IsFstPxl,
  output logic                           PxlCap,
  img_rsz_blk_acc_if.master              CompBlk,
  output logic                           FrmDone
);

  localparam logic [BLK_X_W-1:0] BLK_X_LAST = BLK_X_W'(RSZ_IMG_WIDTH_SIZE - 1);
  localparam logic [BLK_Y_W-1:0] BLK_Y_LAST = BLK_Y_W'(RSZ_IMG_HEIGHT_SIZE - 1);

  BlkAccSt_t                      st_reg;
  logic [BLK_WIDTH_MAX_SZ_W-1:0]  pxl_x_reg;
  logic [BLK_X_W-1:0]             blk_x_reg;
  logic [BLK_HEIGHT_MAX_SZ_W-1:0] line_y_reg;
  logic [BLK_Y_W-1:0]             blk_y_reg;

  FcBlkVal_t                      data_reg;
  logic [RSZ_IMG_WIDTH_SIZE-1:0]  xmsk_reg;
  logic [RSZ_IMG_HEIGHT_SIZE-1:0] ymsk_reg;
  logic                           vld_reg;
  logic                           frm_done_reg;

  logic      pxl_cap;
  logic      accept;
  logic      pxl_x_last;
  logic      line_y_last;
  logic      blk_x_last;
  logic      blk_y_last;
  logic      blk_first;
  logic      blk_last;
  logic      frm_last;
  FcBlkVal_t blk_sum;

  assign pxl_x_last  = (pxl_x_reg == BlkSzHor - BLK_WIDTH_MAX_SZ_W'(1));
  assign line_y_last = (line_y_reg == BlkSzVer - BLK_HEIGHT_MAX_SZ_W'(1));
  assign blk_x_last  = (blk_x_reg == BLK_X_LAST);
  assign blk_y_last  = (blk_y_reg == BLK_Y_LAST);
  assign blk_first   = (pxl_x_reg == '0) && (line_y_reg == '0);
  assign blk_last    = pxl_x_last && line_y_last;
  assign frm_last    = blk_last && blk_x_last && blk_y_last;

  // A held block stalls the source; an accept in this cycle frees the slot at once.
  assign PxlRdy   = ~(vld_reg & ~CompBlk.CompBlkRdy) & (st_reg != ST_FLUSH);
  assign pxl_cap  = PxlVld & PxlRdy;
  assign PxlCap   = pxl_cap;
  assign IsFstPxl = (st_reg == ST_IDLE);
  assign accept   = vld_reg & CompBlk.CompBlkRdy;

  assign CompBlk.CompBlkData = data_reg;
  assign CompBlk.CompBlkXMsk = xmsk_reg;
  assign CompBlk.CompBlkYMsk = ymsk_reg;
  assign CompBlk.CompBlkVld  = vld_reg;
  assign FrmDone             = frm_done_reg;

  img_rsz_acc_row u_acc_row (
    .clk   (Clk),
    .idx   (blk_x_reg),
    .wr_en (pxl_cap),
    .load  (blk_first),
    .pxl   (PxlData),
    .sum   (blk_sum)
  );

  // Raster position counters: pixel-in-block, block column, line-in-block, block row.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pxl_x_reg  <= '0;
      blk_x_reg  <= '0;
      line_y_reg <= '0;
      blk_y_reg  <= '0;
    end else if ((st_reg == ST_FLUSH) && accept) begin
      pxl_x_reg  <= '0;
      blk_x_reg  <= '0;
      line_y_reg <= '0;
      blk_y_reg  <= '0;
    end else if (pxl_cap) begin
      if (!pxl_x_last) begin
        pxl_x_reg <= pxl_x_reg + BLK_WIDTH_MAX_SZ_W'(1);
      end else begin
        pxl_x_reg <= '0;
        if (!blk_x_last) begin
          blk_x_reg <= blk_x_reg + BLK_X_W'(1);
        end else begin
          blk_x_reg <= '0;
          if (!line_y_last) begin
            line_y_reg <= line_y_reg + BLK_HEIGHT_MAX_SZ_W'(1);
          end else begin
            line_y_reg <= '0;
            blk_y_reg  <= blk_y_last ? '0 : blk_y_reg + BLK_Y_W'(1);
          end
        end
      end
    end
  end

  // Output register: a new block-last capture overrides a same-cycle accept.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      data_reg <= '0;
      xmsk_reg <= '0;
      ymsk_reg <= '0;
      vld_reg  <= 1'b0;
    end else begin
      if (accept) begin
        vld_reg <= 1'b0;
      end
      if (pxl_cap && blk_last) begin
        data_reg <= blk_sum;
        xmsk_reg <= RSZ_IMG_WIDTH_SIZE'(1) << blk_x_reg;
        ymsk_reg <= RSZ_IMG_HEIGHT_SIZE'(1) << blk_y_reg;
        vld_reg  <= 1'b1;
      end
    end
  end

  // Frame sequencer; FrmDone pulses the cycle after the final block is accepted.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      st_reg       <= ST_IDLE;
      frm_done_reg <= 1'b0;
    end else begin
      frm_done_reg <= 1'b0;
      case (st_reg)
        ST_IDLE: begin
          // A one-pixel frame finishes on its very first capture.
          if (pxl_cap) begin
            st_reg <= frm_last ? ST_FLUSH : ST_RUN;
          end
        end
        ST_RUN: begin
          if (pxl_cap && frm_last) begin
            st_reg <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (accept) begin
            frm_done_reg <= 1'b1;
            st_reg       <= ST_IDLE;
          end
        end
        default: st_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_img_rsz_blk_acc.sv
// Self-checking bench for img_rsz_blk_acc with a block scoreboard.
module tb_img_rsz_blk_acc;
  import img_rsz_blk_acc_pkg::*;

  localparam int W  = RSZ_IMG_WIDTH_SIZE;
  localparam int H  = RSZ_IMG_HEIGHT_SIZE;
  localparam int NC = PXL_PRIM_COLOR_NUM;

  typedef struct packed {
    FcBlkVal_t    data;
    logic [W-1:0] xmsk;
    logic [H-1:0] ymsk;
  } exp_t;

  logic                           Clk = 1'b0;
  logic                           Reset = 1'b0;
  logic [BLK_WIDTH_MAX_SZ_W-1:0]  BlkSzHor = BLK_WIDTH_MAX_SZ_W'(2);
  logic [BLK_HEIGHT_MAX_SZ_W-1:0] BlkSzVer = BLK_HEIGHT_MAX_SZ_W'(2);
  FcPxl_t                         PxlData = '0;
  logic                           PxlVld = 1'b0;
  logic                           PxlRdy;
  logic                           IsFstPxl;
  logic                           PxlCap;
  logic                           FrmDone;

  img_rsz_blk_acc_if comp_blk ();

  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t exp_q[$];
  int   img [0:7][0:7][0:NC-1];

  always #5 Clk = ~Clk;

  img_rsz_blk_acc dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .BlkSzHor (BlkSzHor),
    .BlkSzVer (BlkSzVer),
    .PxlData  (PxlData),
    .PxlVld   (PxlVld),
    .PxlRdy   (PxlRdy),
    .IsFstPxl (IsFstPxl),
    .PxlCap   (PxlCap),
    .CompBlk  (comp_blk),
    .FrmDone  (FrmDone)
  );

  function automatic FcPxl_t mk_pxl(input int y, input int x);
    FcPxl_t p;
    for (int c = 0; c < NC; c++) p[c] = PXL_PRIM_COLOR_W'(img[y][x][c]);
    return p;
  endfunction

  // Expected block computed directly from the source image.
  function automatic exp_t exp_blk(input int bx, input int by, input int hor, input int ver);
    exp_t e;
    for (int c = 0; c < NC; c++) begin
      int s = 0;
      for (int y = by * ver; y < (by + 1) * ver; y++)
        for (int x = bx * hor; x < (bx + 1) * hor; x++)
          s += img[y][x][c];
      e.data[c] = BLK_SUM_MAX_W'(s);
    end
    e.xmsk     = '0;
    e.xmsk[bx] = 1'b1;
    e.ymsk     = '0;
    e.ymsk[by] = 1'b1;
    return e;
  endfunction

  // Present one pixel until captured; entered and left at posedge+1.
  task automatic drive_pixel(input FcPxl_t d, input bit exp_fst);
    int wait_cyc = 0;
    bit cap = 1'b0;
    PxlData = d;
    PxlVld  = 1'b1;
    while (!cap) begin
      @(negedge Clk);
      cap = PxlRdy;
      if (cap) begin
        tests_run++;
        if (IsFstPxl !== exp_fst) begin
          tests_failed++;
          $display("[TB] FAIL is_fst_pxl: got %0b expected %0b", IsFstPxl, exp_fst);
        end
        tests_run++;
        if (PxlCap !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL pxl_cap: got %0b expected 1", PxlCap);
        end
      end
      @(posedge Clk); #1;
      if (!cap) begin
        wait_cyc++;
        if (wait_cyc > 200) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL pxl_timeout: got no capture expected capture within 200 cycles");
          cap = 1'b1;
        end
      end
    end
    PxlVld = 1'b0;
  endtask

  task automatic drive_frame(input int hor, input int ver);
    for (int y = 0; y < H * ver; y++) begin
      for (int x = 0; x < W * hor; x++) begin
        if ((x % hor == hor - 1) && (y % ver == ver - 1))
          exp_q.push_back(exp_blk(x / hor, y / ver, hor, ver));
        drive_pixel(mk_pxl(y, x), (x == 0) && (y == 0));
      end
    end
  endtask

  // Pops the scoreboard on each accept, applies optional backpressure after block 0.
  task automatic monitor_frame(input int stall_cycles, input bit chk_consec, input string name);
    int got = 0, cyc = 0, last_acc = 0, stall_left = 0;
    bit acc_now;
    exp_t e;
    comp_blk.CompBlkRdy = 1'b1;
    while (got < W * H && cyc < 2000) begin
      @(negedge Clk);
      cyc++;
      acc_now = 1'b0;
      tests_run++;
      if (FrmDone !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL %s frm_done_early: got %0b expected 0", name, FrmDone);
      end
      if (comp_blk.CompBlkVld && !comp_blk.CompBlkRdy) begin
        tests_run++;
        if (PxlRdy !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL %s pxl_rdy_stall: got %0b expected 0", name, PxlRdy);
        end
      end else if (!comp_blk.CompBlkVld) begin
        tests_run++;
        if (PxlRdy !== 1'b1) begin
          tests_failed++;
          $display("[TB] FAIL %s pxl_rdy_free: got %0b expected 1", name, PxlRdy);
        end
      end
      if (comp_blk.CompBlkVld && comp_blk.CompBlkRdy) begin
        acc_now = 1'b1;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL %s unexpected_blk: got block %h expected none", name, comp_blk.CompBlkData);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] %s blk %0d data=%h xmsk=%b ymsk=%b", name, got,
                   comp_blk.CompBlkData, comp_blk.CompBlkXMsk, comp_blk.CompBlkYMsk);
          if (comp_blk.CompBlkData !== e.data || comp_blk.CompBlkXMsk !== e.xmsk ||
              comp_blk.CompBlkYMsk !== e.ymsk) begin
            tests_failed++;
            $display("[TB] FAIL %s blk%0d: got %h/%b/%b expected %h/%b/%b", name, got,
                     comp_blk.CompBlkData, comp_blk.CompBlkXMsk, comp_blk.CompBlkYMsk,
                     e.data, e.xmsk, e.ymsk);
          end
        end
        if (chk_consec && got > 0) begin
          tests_run++;
          if (cyc - last_acc != 1) begin
            tests_failed++;
            $display("[TB] FAIL %s consec: got gap %0d expected 1", name, cyc - last_acc);
          end
        end
        last_acc = cyc;
        got++;
      end
      @(posedge Clk); #1;
      if (acc_now && got == 1 && stall_cycles > 0) begin
        comp_blk.CompBlkRdy = 1'b0;
        stall_left = stall_cycles;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) comp_blk.CompBlkRdy = 1'b1;
      end
    end
    tests_run++;
    if (got != W * H) begin
      tests_failed++;
      $display("[TB] FAIL %s blk_timeout: got %0d blocks expected %0d", name, got, W * H);
    end
    @(negedge Clk);
    tests_run++;
    if (FrmDone !== 1'b1 || IsFstPxl !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL %s frm_done: got %0b/%0b expected 1/1", name, FrmDone, IsFstPxl);
    end
    @(posedge Clk); #1;
    @(negedge Clk);
    tests_run++;
    if (FrmDone !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s frm_done_len: got %0b expected 0", name, FrmDone);
    end
    @(posedge Clk); #1;
  endtask

  task automatic run_frame(input int hor, input int ver, input int stall_cycles,
                           input bit chk_consec, input string name);
    BlkSzHor = BLK_WIDTH_MAX_SZ_W'(hor);
    BlkSzVer = BLK_HEIGHT_MAX_SZ_W'(ver);
    exp_q.delete();
    fork
      drive_frame(hor, ver);
      monitor_frame(stall_cycles, chk_consec, name);
    join
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL %s leftover: got %0d pending expected 0", name, exp_q.size());
    end
  endtask

  task automatic fill_const(input int v);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        for (int c = 0; c < NC; c++) img[y][x][c] = v;
  endtask

  task automatic fill_raster(input int iw);
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        img[y][x][0] = y * iw + x;
        img[y][x][1] = 2 * (y * iw + x);
        img[y][x][2] = 255 - (y * iw + x);
      end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    comp_blk.CompBlkRdy = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    @(negedge Clk);
    tests_run++;
    if (PxlRdy !== 1'b1 || IsFstPxl !== 1'b1 || PxlCap !== 1'b0 || FrmDone !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got rdy/fst/cap/done %0b%0b%0b%0b expected 1100",
               PxlRdy, IsFstPxl, PxlCap, FrmDone);
    end
    tests_run++;
    if (comp_blk.CompBlkVld !== 1'b0 || comp_blk.CompBlkData !== '0 ||
        comp_blk.CompBlkXMsk !== '0 || comp_blk.CompBlkYMsk !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out: got vld=%0b data=%h x=%b y=%b expected all zero",
               comp_blk.CompBlkVld, comp_blk.CompBlkData, comp_blk.CompBlkXMsk, comp_blk.CompBlkYMsk);
    end
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
  endtask

  task automatic test_uniform();
    fill_const(10);
    run_frame(2, 2, 0, 1'b0, "uniform");
  endtask

  task automatic test_backpressure();
    fill_const(10);
    run_frame(2, 2, 5, 1'b0, "backpressure");
  endtask

  task automatic test_raster();
    fill_raster(4);
    run_frame(2, 2, 0, 1'b0, "raster");
  endtask

  task automatic test_back_to_back();
    fill_const(0);
    img[0][0][0] = 3; img[0][1][0] = 7; img[1][0][0] = 5; img[1][1][0] = 9;
    img[0][0][1] = 3; img[0][1][1] = 7; img[1][0][1] = 5; img[1][1][1] = 9;
    img[0][0][2] = 3; img[0][1][2] = 7; img[1][0][2] = 5; img[1][1][2] = 9;
    run_frame(1, 1, 0, 1'b1, "blk1x1");
  endtask

  task automatic test_mid_reset();
    fill_const(10);
    BlkSzHor = BLK_WIDTH_MAX_SZ_W'(2);
    BlkSzVer = BLK_HEIGHT_MAX_SZ_W'(2);
    comp_blk.CompBlkRdy = 1'b0;
    for (int k = 0; k < 6; k++) drive_pixel(mk_pxl(k / 4, k % 4), k == 0);
    @(negedge Clk);
    tests_run++;
    if (comp_blk.CompBlkVld !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_pending: got vld %0b expected 1", comp_blk.CompBlkVld);
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(negedge Clk);
    tests_run++;
    if (comp_blk.CompBlkVld !== 1'b0 || IsFstPxl !== 1'b1 || PxlRdy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset_state: got vld/fst/rdy %0b%0b%0b expected 011",
               comp_blk.CompBlkVld, IsFstPxl, PxlRdy);
    end
    @(posedge Clk); #1;
    fill_raster(4);
    run_frame(2, 2, 0, 1'b0, "after_reset");
  endtask

  task automatic test_max_block();
    fill_const(255);
    run_frame(BLK_WIDTH_MAX_SZ, BLK_HEIGHT_MAX_SZ, 0, 1'b0, "max_blk");
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_backpressure();
    test_raster();
    test_back_to_back();
    test_mid_reset();
    test_max_block();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
